dcc_event_collector: RTL and testbench
======================================

Name: dcc_event_collector

Overview:
- Avalon-MM master that services the 26-bit DCC time-out PIO from the bus-initiator side.
- At start-up it programs the PIO interrupt mask and flushes any stale edges.
- On each PIO irq it reads the edge-capture register, clears it, snapshots the input levels, timestamps the event and pushes a record into a small FIFO.
- The FIFO drains over a valid/ready stream, so downstream logic gets time-out events without a CPU.

Parameters:
- WIDTH, 26, PIO data width (bits of capture and level).
- IRQ_MASK, 26'h3FFFFFF, value written to PIO address 2 at init.
- FIFO_DEPTH, 8, event FIFO entries (power of 2, ≥2).

Ports:
- clk  in  1  clock.
- reset_n  in  1  asynchronous active-low reset.
- enable  in  1  allows irq servicing; init runs regardless.
- avm_address  out  2  PIO register address.
- avm_chipselect  out  1  bus access strobe.
- avm_write_n  out  1  active-low write.
- avm_writedata  out  32  write data.
- avm_readdata  in  32  PIO registered read data; valid the cycle after the read is issued.
- pio_irq  in  1  PIO interrupt (level).
- ev_valid  out  1  FIFO head valid.
- ev_ready  in  1  consumer accepts head.
- ev_capture  out  WIDTH  captured edge bits.
- ev_level  out  WIDTH  input level snapshot.
- ev_timestamp  out  32  cycle count at service start.
- drop_count  out  16  saturating count of records lost to a full FIFO.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset/idle values:
  - Reset (async) forces avm_chipselect=0, avm_write_n=1, avm_address=0, avm_writedata=0, FIFO empty (ev_valid=0), drop_count=0, timestamp counter=0, state=INIT_MASK.
  - The same bus values are held in every non-bus cycle.
- Timestamp: 32-bit free-running counter, +1 per clk, wraps 0xFFFFFFFF→0.
- States (one cycle each unless noted):
  - INIT_MASK: write addr 2, writedata = IRQ_MASK zero-extended to 32 bits. → INIT_CLR.
  - INIT_CLR: write addr 3, writedata=0xFFFFFFFF. → IDLE.
  - IDLE: no bus access; busy=0. If pio_irq & enable → RD_CAP; otherwise stay.
  - RD_CAP: read addr 3 (chipselect=1, write_n=1); latch the timestamp counter into ts_reg. → CLR.
  - CLR: write addr 3, writedata=0xFFFFFFFF; latch avm_readdata[WIDTH-1:0] into cap_reg. → RD_LVL.
  - RD_LVL: read addr 0. → LVL_LAT.
  - LVL_LAT: no bus; latch avm_readdata[WIDTH-1:0] into lvl_reg. → PUSH.
  - PUSH: if cap_reg≠0, push {ts_reg, lvl_reg, cap_reg}; if cap_reg==0, push nothing. → IDLE.
- Service latency: IDLE exit to record visible on ev_valid is 6 cycles (visible the cycle after PUSH). pio_irq falls after CLR, so IDLE does not re-trigger on the same event.
- Known loss window: the PIO clears all capture bits on any write. Edges registered by the PIO during the RD_CAP or CLR cycles are lost. This is accepted behaviour and is not compensated.
- FIFO:
  - ev_valid = not empty; ev_* show the head combinationally.
  - Pop on ev_valid & ev_ready.
  - Push is accepted when not full, or when full with a pop in the same cycle.
  - Otherwise the record is dropped and drop_count increments, saturating at 0xFFFF.
  - Simultaneous push and pop on an empty FIFO: the push is accepted and the pop is impossible (ev_valid=0).
- enable low: the FSM completes any in-progress service sequence, then stays in IDLE. The FIFO still drains.
- avm_readdata[31:WIDTH] is ignored.
- Reset mid-sequence: the in-flight record is discarded, the FIFO is emptied, and the init writes repeat.

Test Plan:
- Reset release → cycle 1: write addr2 data 0x03FFFFFF; cycle 2: write addr3 data 0xFFFFFFFF; then IDLE, busy=0, ev_valid=0.
- PIO model bit 5 edge with in_port=0x20, ev_ready=1 → bus sequence rd3, wr3, rd0. The bench must show exactly this order.
  - Required record: ev_capture=0x20, ev_level=0x20, ev_timestamp = counter value in the RD_CAP cycle.
  - ev_valid rises 6 cycles after IDLE exit and stays high 1 cycle.
- pio_irq asserted while PIO readdata returns 0 for addr 3 → full bus sequence executes, no push, ev_valid stays 0.
- ev_ready=0, 10 events on distinct bits → 8 records in order, drop_count=2.
  - Then ev_ready=1: 8 pops, the first is the first event, FIFO empty.
- FIFO full, ev_ready=1 in the PUSH cycle → record accepted, drop_count unchanged, occupancy stays 8.
- Assert reset_n low during CLR → outputs return to reset values immediately, FIFO empty. After release the init writes recur and the next irq is serviced normally.

Source files
------------

// File: rtl/dcc_event_collector_if.sv
// Avalon-MM bus between the event collector (master) and the DCC time-out PIO (slave).
interface dcc_event_collector_if;
  logic [1:0]  avm_address;
  logic        avm_chipselect;
  logic        avm_write_n;
  logic [31:0] avm_writedata;
  logic [31:0] avm_readdata;

  modport master (
    output avm_address,
    output avm_chipselect,
    output avm_write_n,
    output avm_writedata,
    input  avm_readdata
  );

  modport slave (
    input  avm_address,
    input  avm_chipselect,
    input  avm_write_n,
    input  avm_writedata,
    output avm_readdata
  );
endinterface

// File: rtl/dcc_event_collector.sv
// Services the DCC time-out PIO: programs it at start-up, then turns each irq into a
// timestamped {capture, level} record queued in a small FIFO drained over valid/ready.
module dcc_event_collector #(
  parameter int unsigned      WIDTH      = 26,
  parameter logic [WIDTH-1:0] IRQ_MASK   = WIDTH'(26'h3FF_FFFF),
  parameter int unsigned      FIFO_DEPTH = 8
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  enable,
  dcc_event_collector_if.master avm,
  input  logic                  pio_irq,
  output logic                  ev_valid,
  input  logic                  ev_ready,
  output logic [WIDTH-1:0]      ev_capture,
  output logic [WIDTH-1:0]      ev_level,
  output logic [31:0]           ev_timestamp,
  output logic [15:0]           drop_count,
  output logic                  busy
);

  localparam int unsigned TS_W   = 32;
  localparam int unsigned DROP_W = 16;
  localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);

  localparam logic [1:0]        ADDR_DATA = 2'd0;
  localparam logic [1:0]        ADDR_MASK = 2'd2;
  localparam logic [1:0]        ADDR_EDGE = 2'd3;
  localparam logic [31:0]       CLR_ALL   = 32'hFFFF_FFFF;
  localparam logic [PTR_W:0]    PTR_ONE   = (PTR_W+1)'(1);
  localparam logic [TS_W-1:0]   TS_ONE    = TS_W'(1);
  localparam logic [DROP_W-1:0] DROP_ONE  = DROP_W'(1);

  typedef enum logic [2:0] {
    INIT_MASK,
    INIT_CLR,
    IDLE,
    RD_CAP,
    CLR,
    RD_LVL,
    LVL_LAT,
    PUSH
  } state_t;

  typedef struct packed {
    logic [TS_W-1:0]  ts;
    logic [WIDTH-1:0] lvl;
    logic [WIDTH-1:0] cap;
  } rec_t;

  state_t state_q, state_d;
  logic   init_armed_q;

  logic        cs_q, cs_d;
  logic        wn_q, wn_d;
  logic [1:0]  addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        busy_q;

  logic [TS_W-1:0]  ts_cnt_q;
  logic [TS_W-1:0]  ts_reg;
  logic [WIDTH-1:0] cap_reg;
  logic [WIDTH-1:0] lvl_reg;

  rec_t              mem_q [FIFO_DEPTH];
  logic [PTR_W:0]    wr_ptr_q, rd_ptr_q;
  logic [DROP_W-1:0] drop_q;
  logic              fifo_empty, fifo_full;
  logic              push_req, push_ok, pop;
  rec_t              head;

  logic rd_unused;
  assign rd_unused = ^avm.avm_readdata[31:WIDTH];

  // State register; init_armed_q holds INIT_MASK for the first cycle out of reset
  // so the mask write is driven on the bus while the FSM is in INIT_MASK.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= INIT_MASK;
      init_armed_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      init_armed_q <= 1'b1;
    end
  end

  // Next state, and the bus access belonging to the state being entered.
  always_comb begin
    state_d = state_q;
    cs_d    = 1'b0;
    wn_d    = 1'b1;
    addr_d  = 2'd0;
    wdata_d = 32'd0;

    case (state_q)
      INIT_MASK: if (init_armed_q) state_d = INIT_CLR;
      INIT_CLR:  state_d = IDLE;
      IDLE:      if (pio_irq && enable) state_d = RD_CAP;
      RD_CAP:    state_d = CLR;
      CLR:       state_d = RD_LVL;
      RD_LVL:    state_d = LVL_LAT;
      LVL_LAT:   state_d = PUSH;
      PUSH:      state_d = IDLE;
      default:   state_d = INIT_MASK;
    endcase

    case (state_d)
      INIT_MASK: begin
        cs_d    = 1'b1;
        wn_d    = 1'b0;
        addr_d  = ADDR_MASK;
        wdata_d = 32'(IRQ_MASK);
      end
      INIT_CLR, CLR: begin
        cs_d    = 1'b1;
        wn_d    = 1'b0;
        addr_d  = ADDR_EDGE;
        wdata_d = CLR_ALL;
      end
      RD_CAP: begin
        cs_d   = 1'b1;
        addr_d = ADDR_EDGE;
      end
      RD_LVL: begin
        cs_d   = 1'b1;
        addr_d = ADDR_DATA;
      end
      default: ;
    endcase
  end

  // Registered bus strobes and busy flag, aligned with state_q.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cs_q    <= 1'b0;
      wn_q    <= 1'b1;
      addr_q  <= 2'd0;
      wdata_q <= 32'd0;
      busy_q  <= 1'b1;
    end else begin
      cs_q    <= cs_d;
      wn_q    <= wn_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      busy_q  <= (state_d != IDLE);
    end
  end

  // Free-running timestamp and the per-event snapshot registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ts_cnt_q <= '0;
      ts_reg   <= '0;
      cap_reg  <= '0;
      lvl_reg  <= '0;
    end else begin
      ts_cnt_q <= ts_cnt_q + TS_ONE;
      if (state_q == RD_CAP)  ts_reg  <= ts_cnt_q;
      if (state_q == CLR)     cap_reg <= avm.avm_readdata[WIDTH-1:0];
      if (state_q == LVL_LAT) lvl_reg <= avm.avm_readdata[WIDTH-1:0];
    end
  end

  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                      (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
  assign pop        = !fifo_empty && ev_ready;
  assign push_req   = (state_q == PUSH) && (cap_reg != '0);
  assign push_ok    = push_req && (!fifo_full || pop);

  // FIFO storage; contents need no reset since the pointers define validity.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q[PTR_W-1:0]] <= '{ts: ts_reg, lvl: lvl_reg, cap: cap_reg};
  end

  // FIFO pointers and saturating drop counter.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      drop_q   <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (pop)     rd_ptr_q <= rd_ptr_q + PTR_ONE;
      if (push_req && !push_ok && (drop_q != '1)) drop_q <= drop_q + DROP_ONE;
    end
  end

  assign head = mem_q[rd_ptr_q[PTR_W-1:0]];

  assign ev_valid           = !fifo_empty;
  assign ev_capture         = head.cap;
  assign ev_level           = head.lvl;
  assign ev_timestamp       = head.ts;
  assign drop_count         = drop_q;
  assign busy               = busy_q;
  assign avm.avm_chipselect = cs_q;
  assign avm.avm_write_n    = wn_q;
  assign avm.avm_address    = addr_q;
  assign avm.avm_writedata  = wdata_q;

endmodule

// File: tb/tb_dcc_event_collector.sv
// Bench for dcc_event_collector: a behavioural PIO on the bus, a record scoreboard
// fed as events are driven, and a monitor that checks each popped FIFO record.
module tb_dcc_event_collector;

  localparam int unsigned WIDTH = 26;
  localparam int unsigned DEPTH = 8;
  localparam logic [31:0] MASK32 = 32'h03FF_FFFF;

  typedef struct packed {
    logic [31:0]      ts;
    logic [WIDTH-1:0] lvl;
    logic [WIDTH-1:0] cap;
  } rec_t;

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic             enable = 1'b0;
  logic             pio_irq;
  logic             ev_valid;
  logic             ev_ready = 1'b0;
  logic [WIDTH-1:0] ev_capture;
  logic [WIDTH-1:0] ev_level;
  logic [31:0]      ev_timestamp;
  logic [15:0]      drop_count;
  logic             busy;

  logic [WIDTH-1:0] in_port = '0;
  logic [WIDTH-1:0] pio_prev = '0;
  logic [WIDTH-1:0] pio_cap = '0;
  logic [WIDTH-1:0] pio_mask = '0;
  logic             force_irq = 1'b0;
  logic             force_zero = 1'b0;
  logic [31:0]      tb_cnt;
  logic [WIDTH-1:0] cur_in = '0;

  int   n_chk = 0;
  int   n_fail = 0;
  int   n_pop = 0;
  int   drop_exp = 0;
  rec_t exp_q[$];
  logic [34:0] bus_log[$];

  always #5 clk = ~clk;

  dcc_event_collector_if bus ();

  dcc_event_collector #(
    .WIDTH(WIDTH),
    .IRQ_MASK(26'h3FF_FFFF),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .enable(enable),
    .avm(bus),
    .pio_irq(pio_irq),
    .ev_valid(ev_valid),
    .ev_ready(ev_ready),
    .ev_capture(ev_capture),
    .ev_level(ev_level),
    .ev_timestamp(ev_timestamp),
    .drop_count(drop_count),
    .busy(busy)
  );

  // Behavioural PIO: rising-edge capture, any write to addr 3 clears all, registered reads.
  always @(posedge clk) begin
    pio_prev <= in_port;
    if (bus.avm_chipselect && !bus.avm_write_n && bus.avm_address == 2'd3)
      pio_cap <= '0;
    else
      pio_cap <= pio_cap | (in_port & ~pio_prev);
    if (bus.avm_chipselect && !bus.avm_write_n && bus.avm_address == 2'd2)
      pio_mask <= bus.avm_writedata[WIDTH-1:0];
    if (bus.avm_chipselect && bus.avm_write_n) begin
      case (bus.avm_address)
        2'd0:    bus.avm_readdata <= {6'h2A, in_port};
        2'd2:    bus.avm_readdata <= {6'h2A, pio_mask};
        2'd3:    bus.avm_readdata <= {6'h2A, (force_zero ? {WIDTH{1'b0}} : pio_cap)};
        default: bus.avm_readdata <= 32'd0;
      endcase
    end
  end

  assign pio_irq = (|(pio_cap & pio_mask)) | force_irq;

  // Reference cycle counter: value during a cycle is the edges seen since reset release.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) tb_cnt <= 32'd0;
    else          tb_cnt <= tb_cnt + 32'd1;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] want);
    n_chk++;
    if (obs !== want) begin
      n_fail++;
      $display("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, want);
    end
  endtask

  // Bus log and scoreboard pop, sampled on the falling edge.
  initial begin
    rec_t e;
    forever begin
      @(negedge clk);
      if (reset_n && bus.avm_chipselect)
        bus_log.push_back({bus.avm_write_n, bus.avm_address, bus.avm_writedata});
      if (reset_n && ev_valid && ev_ready) begin
        if (exp_q.size() == 0) begin
          chk("sb_unexpected_pop", 64'(exp_q.size()), 64'd1);
        end else begin
          e = exp_q.pop_front();
          n_pop++;
          chk("ev_capture", 64'(ev_capture), 64'(e.cap));
          chk("ev_level", 64'(ev_level), 64'(e.lvl));
          chk("ev_timestamp", 64'(ev_timestamp), 64'(e.ts));
        end
      end
    end
  end

  task automatic wait_bus(input logic wn, input logic [1:0] a, output bit hit);
    hit = 1'b0;
    for (int i = 0; i < 30 && !hit; i++) begin
      @(negedge clk);
      if (bus.avm_chipselect && bus.avm_write_n == wn && bus.avm_address == a) hit = 1'b1;
    end
  endtask

  task automatic wait_idle(input string tag);
    bit seen_idle;
    seen_idle = 1'b0;
    for (int i = 0; i < 30 && !seen_idle; i++) begin
      @(negedge clk);
      if (!busy) seen_idle = 1'b1;
    end
    chk({tag, "_idle"}, 64'(seen_idle), 64'd1);
  endtask

  task automatic check_init(input string tag);
    @(negedge clk);
    chk({tag, "_mask_cs"}, 64'(bus.avm_chipselect), 64'd1);
    chk({tag, "_mask_wn"}, 64'(bus.avm_write_n), 64'd0);
    chk({tag, "_mask_addr"}, 64'(bus.avm_address), 64'd2);
    chk({tag, "_mask_data"}, 64'(bus.avm_writedata), 64'(MASK32));
    @(negedge clk);
    chk({tag, "_clr_cs"}, 64'(bus.avm_chipselect), 64'd1);
    chk({tag, "_clr_wn"}, 64'(bus.avm_write_n), 64'd0);
    chk({tag, "_clr_addr"}, 64'(bus.avm_address), 64'd3);
    chk({tag, "_clr_data"}, 64'(bus.avm_writedata), 64'hFFFF_FFFF);
    @(negedge clk);
    chk({tag, "_idle_cs"}, 64'(bus.avm_chipselect), 64'd0);
    chk({tag, "_idle_busy"}, 64'(busy), 64'd0);
    chk({tag, "_idle_valid"}, 64'(ev_valid), 64'd0);
  endtask

  // Drive one PIO input change, predict the record, optionally check latency or pop in PUSH.
  task automatic do_event(input string tag, input logic [WIDTH-1:0] new_in,
                          input bit pop_in_push, input bit chk_lat);
    logic [WIDTH-1:0] cap;
    bit   hit;
    int   lat;
    cap = new_in & ~cur_in;
    @(negedge clk);
    in_port = new_in;
    cur_in  = new_in;
    wait_bus(1'b1, 2'd3, hit);
    chk({tag, "_rdcap_seen"}, 64'(hit), 64'd1);
    if (cap != '0) begin
      if (exp_q.size() < DEPTH || pop_in_push)
        exp_q.push_back('{ts: tb_cnt, lvl: new_in, cap: cap});
      else
        drop_exp++;
    end
    if (pop_in_push) begin
      repeat (3) @(negedge clk);
      @(posedge clk);
      #1 ev_ready = 1'b1;
      @(posedge clk);
      #1 ev_ready = 1'b0;
    end
    if (chk_lat) begin
      lat = 0;
      for (int i = 0; i < 10; i++) begin
        @(negedge clk);
        lat++;
        if (ev_valid) break;
      end
      chk({tag, "_latency"}, 64'(lat), 64'd5);
      @(negedge clk);
      chk({tag, "_valid_one_cycle"}, 64'(ev_valid), 64'd0);
    end
    wait_idle(tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit hit;
    int highs;
    int pops0;

    // Reset values and init writes.
    repeat (3) @(negedge clk);
    chk("rst_cs", 64'(bus.avm_chipselect), 64'd0);
    chk("rst_wn", 64'(bus.avm_write_n), 64'd1);
    chk("rst_valid", 64'(ev_valid), 64'd0);
    chk("rst_drop", 64'(drop_count), 64'd0);
    reset_n = 1'b1;
    check_init("init");
    enable = 1'b1;

    // Single event on bit 5, consumer ready: bus order, record, latency.
    @(negedge clk);
    ev_ready = 1'b1;
    bus_log.delete();
    do_event("bit5", 26'h20, 1'b0, 1'b1);
    chk("bit5_busops", 64'(bus_log.size()), 64'd3);
    if (bus_log.size() == 3) begin
      chk("bit5_op0_rd3", 64'(bus_log[0]), 64'({1'b1, 2'd3, 32'd0}));
      chk("bit5_op1_wr3", 64'(bus_log[1]), 64'({1'b0, 2'd3, 32'hFFFF_FFFF}));
      chk("bit5_op2_rd0", 64'(bus_log[2]), 64'({1'b1, 2'd0, 32'd0}));
    end

    // irq with empty capture: full sequence, no record.
    @(negedge clk);
    bus_log.delete();
    force_zero = 1'b1;
    force_irq  = 1'b1;
    wait_bus(1'b1, 2'd3, hit);
    chk("zero_rdcap_seen", 64'(hit), 64'd1);
    wait_bus(1'b0, 2'd3, hit);
    chk("zero_clr_seen", 64'(hit), 64'd1);
    force_irq = 1'b0;
    wait_idle("zero");
    highs = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (ev_valid) highs++;
    end
    force_zero = 1'b0;
    chk("zero_busops", 64'(bus_log.size()), 64'd3);
    chk("zero_no_valid", 64'(highs), 64'd0);
    chk("zero_drop", 64'(drop_count), 64'd0);

    // Ten events with the consumer stalled: eight kept, two dropped.
    @(negedge clk);
    ev_ready = 1'b0;
    in_port  = '0;
    cur_in   = '0;
    repeat (3) @(negedge clk);
    for (int k = 0; k < 10; k++)
      do_event("fill", cur_in | (WIDTH'(1) << k), 1'b0, 1'b0);
    chk("fill_drop", 64'(drop_count), 64'(drop_exp));
    chk("fill_drop_two", 64'(drop_count), 64'd2);
    chk("fill_valid", 64'(ev_valid), 64'd1);

    // Full FIFO with a pop in the PUSH cycle: record accepted, no new drop.
    do_event("fullpop", cur_in | (WIDTH'(1) << 10), 1'b1, 1'b0);
    chk("fullpop_drop", 64'(drop_count), 64'd2);

    // Drain: eight records in order, then empty.
    pops0 = n_pop;
    @(posedge clk);
    #1 ev_ready = 1'b1;
    for (int i = 0; i < 20 && ev_valid; i++) @(negedge clk);
    @(negedge clk);
    chk("drain_pops", 64'(n_pop - pops0), 64'd8);
    chk("drain_sb_empty", 64'(exp_q.size()), 64'd0);
    chk("drain_valid", 64'(ev_valid), 64'd0);

    // Reset asserted during CLR: immediate reset values, init repeats, normal service after.
    @(negedge clk);
    in_port = cur_in | (WIDTH'(1) << 12);
    cur_in  = in_port;
    wait_bus(1'b1, 2'd3, hit);
    chk("rst_mid_rdcap_seen", 64'(hit), 64'd1);
    wait_bus(1'b0, 2'd3, hit);
    chk("rst_mid_clr_seen", 64'(hit), 64'd1);
    reset_n = 1'b0;
    #1;
    chk("rst_mid_cs", 64'(bus.avm_chipselect), 64'd0);
    chk("rst_mid_wn", 64'(bus.avm_write_n), 64'd1);
    chk("rst_mid_addr", 64'(bus.avm_address), 64'd0);
    chk("rst_mid_data", 64'(bus.avm_writedata), 64'd0);
    chk("rst_mid_valid", 64'(ev_valid), 64'd0);
    chk("rst_mid_drop", 64'(drop_count), 64'd0);
    drop_exp = 0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    check_init("reinit");
    highs = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (ev_valid || busy) highs++;
    end
    chk("reinit_quiet", 64'(highs), 64'd0);
    do_event("post_rst", cur_in | (WIDTH'(1) << 13), 1'b0, 1'b1);
    chk("post_rst_drop", 64'(drop_count), 64'd0);
    chk("end_sb_empty", 64'(exp_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
